// File: rtl/print_motor_sequencer.sv
// Print-motor step sequencer: idle, anilox idle-spin, rate-limited speed ramp,
// locked run and braking back to the anilox rate, driving one step square wave.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | motor stopped, step_out held low, cur_half parked at anilox
// ANILOX | idle-spin at the anilox half-period
// RAMP   | cur_half stepping toward the captured target each ramp tick
// RUN    | locked at target; small target changes applied at a toggle
// BRAKE  | cur_half stepping back toward the anilox half-period
module print_motor_sequencer #(
  parameter int PERIOD_W    = 32,
  parameter int ANILOX_HALF = 1000,
  parameter int MIN_HALF    = 50,
  parameter int MAX_HALF    = 500000,
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stop_req,
  input  logic                anilox_disable,
  input  logic [PERIOD_W-1:0] target_half,
  input  logic                target_valid,
  output logic                step_out,
  output logic [2:0]          state,
  output logic [PERIOD_W-1:0] cur_half,
  output logic                at_speed
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ANILOX = 3'd1,
    S_RAMP   = 3'd2,
    S_RUN    = 3'd3,
    S_BRAKE  = 3'd4
  } state_t;

  localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [PERIOD_W-1:0] ANI_V  = PERIOD_W'(ANILOX_HALF);
  localparam logic [PERIOD_W-1:0] MIN_V  = PERIOD_W'(MIN_HALF);
  localparam logic [PERIOD_W-1:0] MAX_V  = PERIOD_W'(MAX_HALF);
  localparam logic [PERIOD_W-1:0] STEP_V = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] ONE_V  = PERIOD_W'(1);
  localparam logic [RDIV_W-1:0]   RDIV_LAST = RDIV_W'(RAMP_DIV - 1);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] tgt;
  logic                tgt_loaded;
  logic [RDIV_W-1:0]   rdiv;
  logic [PERIOD_W-1:0] scnt, scnt_d;
  logic [PERIOD_W-1:0] cur_d;
  logic                step_d;
  logic                at_speed_d;
  logic                tick;
  logic                run_ok;
  logic                toggle;
  logic                small_change;

  // Difference-based step toward a goal: clamps onto the goal instead of
  // overshooting, and never subtracts past zero.
  function automatic logic [PERIOD_W-1:0] move_toward(
    input logic [PERIOD_W-1:0] cur,
    input logic [PERIOD_W-1:0] goal
  );
    logic [PERIOD_W-1:0] diff;
    if (cur > goal) begin
      diff = cur - goal;
      move_toward = (diff <= STEP_V) ? goal : cur - STEP_V;
    end else begin
      diff = goal - cur;
      move_toward = (diff <= STEP_V) ? goal : cur + STEP_V;
    end
  endfunction

  function automatic logic [PERIOD_W-1:0] abs_diff(
    input logic [PERIOD_W-1:0] a,
    input logic [PERIOD_W-1:0] b
  );
    abs_diff = (a > b) ? a - b : b - a;
  endfunction

  assign state        = state_q;
  assign run_ok       = !stop_req && tgt_loaded;
  assign tick         = (rdiv == RDIV_LAST);
  assign toggle       = (state_q != S_IDLE) && (scnt >= cur_half - ONE_V);
  assign small_change = (abs_diff(tgt, cur_half) <= STEP_V);

  // Free-running ramp divider, independent of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdiv <= '0;
    else if (tick) rdiv <= '0;
    else           rdiv <= rdiv + RDIV_W'(1);
  end

  // Target capture with clamping; loaded flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt        <= ANI_V;
      tgt_loaded <= 1'b0;
    end else if (target_valid) begin
      tgt        <= (target_half < MIN_V) ? MIN_V :
                    (target_half > MAX_V) ? MAX_V : target_half;
      tgt_loaded <= 1'b1;
    end
  end

  // State register and step-generator datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_out <= 1'b0;
      cur_half <= ANI_V;
      scnt     <= '0;
      at_speed <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_out <= step_d;
      cur_half <= cur_d;
      scnt     <= scnt_d;
      at_speed <= at_speed_d;
    end
  end

  // Next-state, half-period update and step generation.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_half;
    step_d  = step_out;
    scnt_d  = scnt;

    if (state_q != S_IDLE) begin
      if (toggle) begin
        step_d = ~step_out;
        scnt_d = '0;
      end else begin
        scnt_d = scnt + ONE_V;
      end
    end

    case (state_q)
      S_IDLE: begin
        cur_d  = ANI_V;
        step_d = 1'b0;
        scnt_d = '0;
        if (run_ok)               state_d = S_RAMP;
        else if (!anilox_disable) state_d = S_ANILOX;
      end
      S_ANILOX: begin
        if (run_ok)              state_d = S_RAMP;
        else if (anilox_disable) state_d = S_IDLE;
      end
      S_RAMP: begin
        if (!run_ok) begin
          state_d = S_BRAKE;
        end else begin
          if (tick && (cur_half != tgt)) cur_d = move_toward(cur_half, tgt);
          if (cur_half == tgt) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!run_ok) begin
          state_d = S_BRAKE;
        end else if (tgt != cur_half) begin
          // Small trims land on a toggle so no half-period is cut short mid-way.
          if (small_change) begin
            if (toggle) cur_d = tgt;
          end else begin
            state_d = S_RAMP;
          end
        end
      end
      S_BRAKE: begin
        if (run_ok) begin
          state_d = S_RAMP;
        end else if (cur_half == ANI_V) begin
          state_d = anilox_disable ? S_IDLE : S_ANILOX;
        end else if (tick) begin
          cur_d = move_toward(cur_half, ANI_V);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entry to IDLE is the only place the step phase is forced.
    if (state_d == S_IDLE) begin
      step_d = 1'b0;
      scnt_d = '0;
      cur_d  = ANI_V;
    end

    at_speed_d = (state_d == S_RUN);
  end

endmodule

// File: tb/tb_print_motor_sequencer.sv
// Directed bench for print_motor_sequencer with small timing parameters.
module tb_print_motor_sequencer;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stop_req;
  logic          anilox_disable;
  logic [PW-1:0] target_half;
  logic          target_valid;
  logic          step_out;
  logic [2:0]    state;
  logic [PW-1:0] cur_half;
  logic          at_speed;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] seen_val [16];
  int          seen_gap [16];
  int          seen_n;

  print_motor_sequencer #(
    .PERIOD_W(PW), .ANILOX_HALF(20), .MIN_HALF(4), .MAX_HALF(1000),
    .RAMP_STEP(4), .RAMP_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .stop_req(stop_req), .anilox_disable(anilox_disable),
    .target_half(target_half), .target_valid(target_valid),
    .step_out(step_out), .state(state), .cur_half(cur_half), .at_speed(at_speed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    n_err++;
    $display("FAIL %s: timeout", tag);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_target(input logic [31:0] v);
    target_half  = v;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  // Count cycles until step_out changes level.
  task automatic wait_toggle(input string tag, output int n);
    logic prev;
    bit   done;
    prev = step_out;
    done = 0;
    n    = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (step_out !== prev) done = 1;
    end
    if (!done) timeout(tag);
  endtask

  // Log every cur_half change until the FSM reaches end_state.
  task automatic collect_until(input string tag, input logic [2:0] end_state, input int limit);
    logic [31:0] last;
    int gap, n;
    bit done;
    last = cur_half; gap = 0; n = 0; done = 0; seen_n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++; gap++;
      if (cur_half !== last) begin
        if (seen_n < 16) begin
          seen_val[seen_n] = cur_half;
          seen_gap[seen_n] = gap;
        end
        seen_n++;
        gap  = 0;
        last = cur_half;
      end
      if (seen_n > 0 && state == end_state) done = 1;
    end
    if (!done) timeout(tag);
  endtask

  // Expected ramp: cnt changes, first, first+delta, ..., last; ticks 8 clk apart.
  task automatic check_ramp(input string tag, input int cnt, input int first,
                            input int delta, input int last);
    int bad;
    chk({tag, "_count"}, 32'(seen_n), 32'(cnt));
    if (seen_n == cnt) begin
      for (int i = 0; i < cnt; i++)
        chk($sformatf("%s_val%0d", tag, i), seen_val[i],
            (i == cnt - 1) ? 32'(last) : 32'(first + i * delta));
      bad = 0;
      for (int i = 1; i < cnt; i++) if (seen_gap[i] != 8) bad++;
      chk({tag, "_tick_gaps"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int  n, bad;
    bit  got;
    logic prev;

    rst = 1'b1; stop_req = 1'b1; anilox_disable = 1'b0;
    target_valid = 1'b0; target_half = '0;

    // 1. reset and anilox spin
    cycles(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_cur", cur_half, 32'd20);
    chk("rst_at_speed", 32'(at_speed), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_anilox", 32'(state), 32'd1);
    wait_toggle("t1_sync", n);
    wait_toggle("t1_half_a", n); chk("t1_half_a", 32'(n), 32'd20);
    wait_toggle("t1_half_b", n); chk("t1_half_b", 32'(n), 32'd20);

    // 2. ramp 20 -> 8 and lock
    stop_req = 1'b0;
    pulse_target(32'd8);
    collect_until("t2_ramp", 3'd3, 200);
    check_ramp("t2_ramp", 3, 16, -4, 8);
    chk("t2_run", 32'(state), 32'd3);
    chk("t2_at_speed", 32'(at_speed), 32'd1);
    wait_toggle("t2_sync", n);
    wait_toggle("t2_half_a", n); chk("t2_half_a", 32'(n), 32'd8);
    wait_toggle("t2_half_b", n); chk("t2_half_b", 32'(n), 32'd8);

    // 3. small trim to 10 at a toggle, then ramp to 30, then back to 8
    pulse_target(32'd10);
    got = 0; prev = step_out;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (cur_half == 32'd10) got = 1;
      else prev = step_out;
    end
    chk("t3_trim_cur", cur_half, 32'd10);
    chk("t3_trim_on_toggle", 32'(step_out != prev), 32'd1);
    chk("t3_trim_stays_run", 32'(state), 32'd3);
    wait_toggle("t3_half10", n); chk("t3_half10", 32'(n), 32'd10);
    pulse_target(32'd30);
    collect_until("t3_ramp_up", 3'd3, 300);
    check_ramp("t3_ramp_up", 5, 14, 4, 30);
    pulse_target(32'd8);
    collect_until("t3_ramp_dn", 3'd3, 300);
    check_ramp("t3_ramp_dn", 6, 26, -4, 8);

    // 4. brake to anilox, then brake to idle
    stop_req = 1'b1;
    collect_until("t4_brake", 3'd1, 200);
    check_ramp("t4_brake", 3, 12, 4, 20);
    chk("t4_anilox", 32'(state), 32'd1);
    stop_req = 1'b0;
    collect_until("t4_rerun", 3'd3, 200);
    check_ramp("t4_rerun", 3, 16, -4, 8);
    stop_req = 1'b1; anilox_disable = 1'b1;
    collect_until("t4_brake_idle", 3'd0, 200);
    check_ramp("t4_brake_idle", 3, 12, 4, 20);
    chk("t4_idle_step", 32'(step_out), 32'd0);
    chk("t4_idle_at_speed", 32'(at_speed), 32'd0);
    cycles(10);
    chk("t4_idle_hold", 32'(state), 32'd0);

    // 5. clamps and coincident tick
    pulse_target(32'd0);
    chk("t5_clamp_lo", dut.tgt, 32'd4);
    stop_req = 1'b0;
    collect_until("t5_ramp4", 3'd3, 200);
    check_ramp("t5_ramp4", 4, 16, -4, 4);
    pulse_target(32'd5000);
    chk("t5_clamp_hi", dut.tgt, 32'd1000);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cur_half != 32'd4) got = 1;
    end
    chk("t5_first_up", cur_half, 32'd8);
    cycles(7);
    target_half = 32'd2; target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    chk("t5_tick_old_tgt", cur_half, 32'd12);
    chk("t5_clamp_lo2", dut.tgt, 32'd4);
    cycles(8);
    chk("t5_tick_new_tgt", cur_half, 32'd8);
    chk("t5_still_ramp", 32'(state), 32'd2);

    // 6. async reset during ramp
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_cur", cur_half, 32'd20);
    chk("t6_rst_step", 32'(step_out), 32'd0);
    chk("t6_rst_at_speed", 32'(at_speed), 32'd0);
    @(negedge clk);
    stop_req = 1'b0; anilox_disable = 1'b0; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == 3'd2 || state == 3'd3) bad++;
    end
    chk("t6_no_run_unloaded", 32'(bad), 32'd0);
    chk("t6_anilox", 32'(state), 32'd1);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (step_out) got = 1;
    end
    if (!got) timeout("t6_step_high");
    anilox_disable = 1'b1;
    @(negedge clk);
    chk("t6_anilox_to_idle", 32'(state), 32'd0);
    chk("t6_idle_step_low", 32'(step_out), 32'd0);
    anilox_disable = 1'b0;
    pulse_target(32'd8);
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (state == 3'd2) got = 1;
    end
    chk("t6_ramp_after_load", 32'(state), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
